// File: rtl/arbiter_word_packer_if.sv
// Byte-in / word-out bus of the arbiter word packer.
// Handshake: a byte is taken on every edge where in_valid=1 (no backpressure);
// a word is popped on every edge where ren=1 and empty=0, and dout/keep are
// then presented with valid=1 for exactly the following cycle.
interface arbiter_word_packer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        flush;
    logic        ren;
    logic [31:0] dout;
    logic [3:0]  keep;
    logic        valid;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [1:0]  dbg_cnt;

    modport master (
        output in_valid, in_data, flush, ren,
        input  dout, keep, valid, full, empty, overflow, dbg_cnt
    );

    modport slave (
        input  in_valid, in_data, flush, ren,
        output dout, keep, valid, full, empty, overflow, dbg_cnt
    );
endinterface

// File: rtl/arbiter_word_packer.sv
// Packs the arbiter byte stream into little-endian 32-bit words with lane masks,
// buffers completed words in a small FIFO and presents them on a registered read port.
module arbiter_word_packer #(
    parameter int DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    arbiter_word_packer_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Packer state
    logic [1:0]  r_cnt;
    logic [31:0] r_asm_data;
    logic [3:0]  r_asm_keep;
    logic [31:0] w_asm_data;
    logic [3:0]  w_asm_keep;
    logic        w_push;

    // Word FIFO state
    logic [35:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_accept;
    logic          w_drop;

    // Output register
    logic [31:0] r_dout;
    logic [3:0]  r_keep;
    logic        r_valid;

    // Incoming byte merged into the assembly word; a same-cycle flush sees it.
    always_comb begin
        w_asm_data = r_asm_data;
        w_asm_keep = r_asm_keep;
        if (bus.in_valid) begin
            w_asm_data[{r_cnt, 3'b000} +: 8] = bus.in_data;
            w_asm_keep[r_cnt]                = 1'b1;
        end
        w_push = (bus.in_valid && (r_cnt == 2'd3))
              || (bus.flush && ((r_cnt != 2'd0) || bus.in_valid));
    end

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_pop    = bus.ren && !w_empty;
    // A pop frees the slot the same edge, so a full FIFO can still accept.
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= 2'd0;
            r_asm_data <= '0;
            r_asm_keep <= '0;
        end else if (w_push) begin
            r_cnt      <= 2'd0;
            r_asm_data <= '0;
            r_asm_keep <= '0;
        end else if (bus.in_valid) begin
            r_cnt      <= r_cnt + 2'd1;
            r_asm_data <= w_asm_data;
            r_asm_keep <= w_asm_keep;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_accept) begin
                r_mem[r_wr_ptr] <= {w_asm_keep, w_asm_data};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // When full, wr_ptr == rd_ptr: the read here sees the old entry before the write lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout  <= '0;
            r_keep  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_pop) begin
                r_dout <= r_mem[r_rd_ptr][31:0];
                r_keep <= r_mem[r_rd_ptr][35:32];
            end
        end
    end

    assign bus.dout     = r_dout;
    assign bus.keep     = r_keep;
    assign bus.valid    = r_valid;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.overflow = r_overflow;
    assign bus.dbg_cnt  = r_cnt;
endmodule

// File: tb/tb_arbiter_word_packer.sv
// Bench for arbiter_word_packer: vector table, corner-case sequences and a random run,
// all checked against a byte-level reference model with an expected-word queue.
module tb_arbiter_word_packer;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    arbiter_word_packer_if bus ();

    arbiter_word_packer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [35:0] exp_q[$];
    int          m_cnt;
    logic [31:0] m_word;
    logic [3:0]  m_keep;
    int          m_occ;
    bit          m_ovf;
    bit          m_valid;
    logic [31:0] m_dout;
    logic [3:0]  m_keepout;

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          f;
        bit          r;
        bit          e_valid;
        logic [31:0] e_dout;
        logic [3:0]  e_keep;
        bit          e_empty;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt     = 0;
        m_word    = '0;
        m_keep    = '0;
        m_occ     = 0;
        m_ovf     = 1'b0;
        m_valid   = 1'b0;
        m_dout    = '0;
        m_keepout = '0;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.flush    = 1'b0;
        bus.ren      = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk("rst_dout", {4'h0, bus.dout}, 36'h0);
        chk("rst_keep", {32'h0, bus.keep}, 36'h0);
        chk("rst_valid", {35'h0, bus.valid}, 36'h0);
        chk("rst_full", {35'h0, bus.full}, 36'h0);
        chk("rst_empty", {35'h0, bus.empty}, 36'h1);
        chk("rst_overflow", {35'h0, bus.overflow}, 36'h0);
        chk("rst_cnt", {34'h0, bus.dbg_cnt}, 36'h0);
    endtask

    // Driver: apply one cycle of inputs, advance the model, compare after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit f, input bit r);
        bit          pop;
        bit          close;
        logic [31:0] w;
        logic [3:0]  k;
        logic [35:0] head;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.flush    = f;
        bus.ren      = r;
        pop   = r && (m_occ != 0);
        w     = m_word;
        k     = m_keep;
        if (v) begin
            w[m_cnt*8 +: 8] = d;
            k[m_cnt]        = 1'b1;
        end
        close = (v && (m_cnt == 3)) || (f && ((m_cnt != 0) || v));
        @(posedge clk);
        if (pop) m_occ--;
        m_valid = pop;
        if (close) begin
            if (m_occ < DEPTH) begin
                exp_q.push_back({k, w});
                m_occ++;
            end else begin
                m_ovf = 1'b1;
            end
            m_cnt  = 0;
            m_word = '0;
            m_keep = '0;
        end else if (v) begin
            m_cnt++;
            m_word = w;
            m_keep = k;
        end
        #1;
        chk("valid", {35'h0, bus.valid}, {35'h0, m_valid});
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_nonempty", 36'h0, 36'h1);
            end else begin
                head      = exp_q.pop_front();
                m_dout    = head[31:0];
                m_keepout = head[35:32];
            end
        end
        chk("dout", {4'h0, bus.dout}, {4'h0, m_dout});
        chk("keep", {32'h0, bus.keep}, {32'h0, m_keepout});
        chk("full", {35'h0, bus.full}, {35'h0, (m_occ == DEPTH)});
        chk("empty", {35'h0, bus.empty}, {35'h0, (m_occ == 0)});
        chk("overflow", {35'h0, bus.overflow}, {35'h0, m_ovf});
        chk("cnt", {34'h0, bus.dbg_cnt}, 36'(m_cnt));
    endtask

    initial begin
        logic [31:0] ew;
        tbl[0]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b1};
        tbl[1]  = '{1'b1, 8'h0B, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b1};
        tbl[2]  = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b1};
        tbl[3]  = '{1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h0D0C0B0A, 4'hF, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0D0C0B0A, 4'hF, 1'b1};
        tbl[6]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 32'h0D0C0B0A, 4'hF, 1'b1};
        tbl[7]  = '{1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 32'h0D0C0B0A, 4'hF, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0D0C0B0A, 4'hF, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h00001514, 4'h3, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h00001514, 4'h3, 1'b1};
        tbl[11] = '{1'b1, 8'h1E, 1'b0, 1'b0, 1'b0, 32'h00001514, 4'h3, 1'b1};
        tbl[12] = '{1'b1, 8'h1F, 1'b1, 1'b0, 1'b0, 32'h00001514, 4'h3, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h00001F1E, 4'h3, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h00001F1E, 4'h3, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h00001F1E, 4'h3, 1'b1};

        do_reset();

        // Full word, flush with/without byte, empty read
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), {35'h0, bus.valid}, {35'h0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_dout", i), {4'h0, bus.dout}, {4'h0, tbl[i].e_dout});
            chk($sformatf("tbl%0d_keep", i), {32'h0, bus.keep}, {32'h0, tbl[i].e_keep});
            chk($sformatf("tbl%0d_empty", i), {35'h0, bus.empty}, {35'h0, tbl[i].e_empty});
            chk($sformatf("tbl%0d_full", i), {35'h0, bus.full}, 36'h0);
        end

        // Overflow: 20 bytes, no reads
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 15) chk("ovf_full_before_16", {35'h0, bus.full}, 36'h0);
            if (i == 16) chk("ovf_full_after_16", {35'h0, bus.full}, 36'h1);
            if (i == 19) chk("ovf_flag_before_drop", {35'h0, bus.overflow}, 36'h0);
            if (i == 20) chk("ovf_flag_after_drop", {35'h0, bus.overflow}, 36'h1);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            ew = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
            chk($sformatf("ovf_word%0d", i), {4'h0, bus.dout}, {4'h0, ew});
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_empty_after_drain", {35'h0, bus.empty}, 36'h1);
        chk("ovf_sticky", {35'h0, bus.overflow}, 36'h1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h31, 1'b0, 1'b0);
        step(1'b1, 8'h32, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h34, 1'b0, 1'b1);
        chk("pp_full_kept", {35'h0, bus.full}, 36'h1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pp_head_out", {4'h0, bus.dout}, {4'h0, 32'h04030201});
        chk("pp_no_overflow", {35'h0, bus.overflow}, 36'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pp_new_word_last", {4'h0, bus.dout}, {4'h0, 32'h34333231});

        // Reset mid-word
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_mid_dout", {4'h0, bus.dout}, {4'h0, 32'h04030201});
        chk("rst_mid_keep", {32'h0, bus.keep}, {32'h0, 4'hF});

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("final_scoreboard_drained", 36'(exp_q.size()), 36'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
